// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus AXI4-Stream master bundle for the censor stream drain engine.
// The master modport is the reader's view; slave is the FIFO/sink environment.
interface fifo_stream_reader_if #(
   parameter int DATA_W = 8
);
   logic              enable;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_read_en;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic              m_axis_tuser;
   logic              busy;

   modport master (
      input  enable, fifo_empty, fifo_data, m_axis_tready,
      output fifo_read_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy
   );

   modport slave (
      output enable, fifo_empty, fifo_data, m_axis_tready,
      input  fifo_read_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a byte FIFO with a 1-cycle registered read into an AXI4-Stream master,
// using a 2-entry skid buffer so reads can stream at 1 beat/cycle under backpressure.
module fifo_stream_reader #(
   parameter int DATA_W  = 8,
   parameter int PKT_LEN = 64
) (
   input logic                  clock,
   input logic                  reset,
   fifo_stream_reader_if.master bus
);
   localparam int               CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

   logic [1:0]        occ;
   logic              inflight;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [CNT_W-1:0]  beat;
   logic              valid;
   logic              pop;
   logic              read_en;
   logic [2:0]        level;
   logic [1:0]        wr_slot;

   assign valid = (occ != 2'd0);
   assign pop   = valid & bus.m_axis_tready;

   // Occupancy the buffer will have after this edge, counting the byte already in flight.
   // A new strobe is allowed only if its byte is guaranteed a slot two edges from now.
   assign level   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign read_en = ~reset & bus.enable & ~bus.fifo_empty & (level < 3'd2);

   // Captured byte lands behind whatever survives this cycle's pop.
   assign wr_slot = occ - {1'b0, pop};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= read_en;
         occ      <= occ + {1'b0, inflight} - {1'b0, pop};
         if (pop)
            head <= tail;
         if (inflight) begin
            if (wr_slot == 2'd0)
               head <= bus.fifo_data;
            else
               tail <= bus.fifo_data;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         beat <= '0;
      else if (pop)
         beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
   end

   assign bus.fifo_read_en  = read_en;
   assign bus.m_axis_tvalid = valid;
   assign bus.m_axis_tdata  = head;
   assign bus.m_axis_tlast  = valid & (beat == LAST_BEAT);
   assign bus.m_axis_tuser  = valid & (beat == '0);
   assign bus.busy          = inflight | valid;
endmodule
